// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: widths, codeword bit layout and the encoder.
// Reused by the transmitter and by the error corrector at the far end of the link.
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;

  localparam int POS_P1 = 0;
  localparam int POS_P2 = 1;
  localparam int POS_D0 = 2;
  localparam int POS_P4 = 3;
  localparam int POS_D1 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

  // Even parity: each parity bit covers the data bits whose position index has that bit set.
  function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    c         = '0;
    c[POS_D0] = d[0];
    c[POS_D1] = d[1];
    c[POS_D2] = d[2];
    c[POS_D3] = d[3];
    c[POS_P1] = d[0] ^ d[1] ^ d[3];
    c[POS_P2] = d[0] ^ d[2] ^ d[3];
    c[POS_P4] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

endpackage

// File: rtl/hamming_tx_if.sv
// Nibble-in handshake plus parallel and serial codeword outputs of the Hamming transmitter.
interface hamming_tx_if;
  import hamming_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [2:0]        err_pos;
  logic [CODE_W-1:0] code_out;
  logic              code_valid;
  logic              ser_out;
  logic              ser_frame;

  modport master (
    output in_valid, in_data, err_pos,
    input  in_ready, code_out, code_valid, ser_out, ser_frame
  );

  modport slave (
    input  in_valid, in_data, err_pos,
    output in_ready, code_out, code_valid, ser_out, ser_frame
  );

endinterface

// File: rtl/hamming_tx.sv
// Hamming(7,4) transmitter: encodes an accepted nibble, optionally flips one bit,
// and shifts the codeword out LSB first with each bit held BIT_CYCLES clocks.
module hamming_tx
  import hamming_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  hamming_tx_if.slave  tx
);

  localparam logic [7:0] CNT_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [2:0] BIT_LAST = 3'd6;

  tx_state_e         state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [CODE_W-1:0] shift_q, shift_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              cv_q, cv_d;
  logic [CODE_W-1:0] inj_mask;

  // err_pos 0 means no injection, so it is screened out before the 3-bit subtract.
  always_comb begin
    inj_mask = '0;
    if (tx.err_pos != 3'd0) begin
      inj_mask = 7'd1 << (tx.err_pos - 3'd1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    code_d  = code_q;
    cv_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx.in_valid) begin
          code_d  = hamming_encode(tx.in_data) ^ inj_mask;
          shift_d = hamming_encode(tx.in_data) ^ inj_mask;
          cv_d    = 1'b1;
          cnt_d   = 8'd0;
          bit_d   = 3'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 8'd0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = 3'd0;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 3'd0;
      shift_q <= '0;
      code_q  <= '0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      code_q  <= code_d;
      cv_q    <= cv_d;
    end
  end

  assign tx.in_ready   = (state_q == ST_IDLE);
  assign tx.ser_frame  = (state_q == ST_SHIFT);
  assign tx.ser_out    = (state_q == ST_SHIFT) & shift_q[0];
  assign tx.code_out   = code_q;
  assign tx.code_valid = cv_q;

endmodule
